// File: rtl/gb_apu_function_length.sv
// Length counter for one Game Boy APU channel: a trigger loads the counter,
// length ticks count it up, and overflow past all-ones shuts the channel off.
module gb_apu_function_length #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_length_ctr,
  input  logic             start,
  input  logic             single,
  input  logic [WIDTH-1:0] length,
  output logic             enable
);

  logic [WIDTH-1:0] counter_q;
  logic [WIDTH-1:0] counter_d;
  logic             enable_q;
  logic             enable_d;

  // Next-state: a trigger beats a tick; a tick only advances a running, length-enabled channel.
  always_comb begin
    counter_d = counter_q;
    enable_d  = enable_q;
    if (start) begin
      counter_d = length;
      enable_d  = 1'b1;
    end else if (clk_length_ctr && enable_q && single) begin
      if (&counter_q) begin
        counter_d = {WIDTH{1'b0}};
        enable_d  = 1'b0;
      end else begin
        counter_d = counter_q + {{(WIDTH-1){1'b0}}, 1'b1};
        enable_d  = enable_q;
      end
    end else begin
      counter_d = counter_q;
      enable_d  = enable_q;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      counter_q <= {WIDTH{1'b0}};
      enable_q  <= 1'b0;
    end else begin
      counter_q <= counter_d;
      enable_q  <= enable_d;
    end
  end

  assign enable = enable_q;

endmodule

// File: tb/tb_gb_apu_function_length.sv
// Directed bench for the length counter: a 6-bit and an 8-bit instance,
// with expected values worked out by hand from the channel behaviour.
module tb_gb_apu_function_length;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick6, start6, single6;
  logic [5:0] length6;
  logic       enable6;
  logic       tick8, start8, single8;
  logic [7:0] length8;
  logic       enable8;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  gb_apu_function_length #(.WIDTH(6)) dut6 (
    .clk(clk), .reset(reset), .clk_length_ctr(tick6), .start(start6),
    .single(single6), .length(length6), .enable(enable6)
  );

  gb_apu_function_length #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .clk_length_ctr(tick8), .start(start8),
    .single(single8), .length(length8), .enable(enable8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // All drives happen 1 time unit after a rising edge; checks follow the next edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_6();
    tick6 = 1'b1;
    cycle();
    tick6 = 1'b0;
  endtask

  task automatic tick_8();
    tick8 = 1'b1;
    cycle();
    tick8 = 1'b0;
  endtask

  task automatic start_6(input logic [5:0] len, input int cycles);
    length6 = len;
    start6  = 1'b1;
    for (int i = 0; i < cycles; i++) cycle();
    start6  = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    tick6 = 1'b0; start6 = 1'b0; single6 = 1'b0; length6 = 6'd0;
    tick8 = 1'b0; start8 = 1'b0; single8 = 1'b0; length8 = 8'd0;
    cycle();
    // Inputs active while in reset must not matter.
    start6 = 1'b1; length6 = 6'd33;
    cycle();
    cycle();
    check("reset_enable6", {31'd0, enable6}, 32'd0);
    check("reset_counter6", {26'd0, dut6.counter_q}, 32'd0);
    check("reset_enable8", {31'd0, enable8}, 32'd0);
    start6 = 1'b0;
    reset  = 1'b1;
    cycle();

    // 1. Expiry after 64-60 = 4 ticks, start held two cycles.
    single6 = 1'b1;
    start_6(6'd60, 2);
    check("t1_start_enable", {31'd0, enable6}, 32'd1);
    check("t1_start_counter", {26'd0, dut6.counter_q}, 32'd60);
    for (int i = 1; i <= 10; i++) begin
      tick_6();
      check($sformatf("t1_tick%0d_enable", i), {31'd0, enable6}, (i < 4) ? 32'd1 : 32'd0);
    end
    check("t1_frozen_counter", {26'd0, dut6.counter_q}, 32'd0);

    // 2. length=0 runs the full 64 ticks.
    start_6(6'd0, 1);
    check("t2_start_enable", {31'd0, enable6}, 32'd1);
    for (int i = 1; i <= 64; i++) begin
      tick_6();
      if (i >= 62) check($sformatf("t2_tick%0d_enable", i), {31'd0, enable6}, (i < 64) ? 32'd1 : 32'd0);
    end
    check("t2_end_counter", {26'd0, dut6.counter_q}, 32'd0);

    // 3. Infinite mode holds the count, then length mode expires it on one tick.
    single6 = 1'b0;
    start_6(6'd63, 1);
    for (int i = 1; i <= 100; i++) tick_6();
    check("t3_inf_enable", {31'd0, enable6}, 32'd1);
    check("t3_inf_counter", {26'd0, dut6.counter_q}, 32'd63);
    single6 = 1'b1;
    tick_6();
    check("t3_single_enable", {31'd0, enable6}, 32'd0);
    check("t3_single_counter", {26'd0, dut6.counter_q}, 32'd0);

    // 4. Simultaneous start and tick: tick ignored.
    length6 = 6'd62; start6 = 1'b1; tick6 = 1'b1;
    cycle();
    start6 = 1'b0; tick6 = 1'b0;
    check("t4_counter", {26'd0, dut6.counter_q}, 32'd62);
    check("t4_enable", {31'd0, enable6}, 32'd1);
    tick_6();
    check("t4_tick1_enable", {31'd0, enable6}, 32'd1);
    tick_6();
    check("t4_tick2_enable", {31'd0, enable6}, 32'd0);

    // 5. Asynchronous reset between edges.
    start_6(6'd60, 1);
    tick_6();
    tick_6();
    check("t5_mid_counter", {26'd0, dut6.counter_q}, 32'd62);
    #2;
    reset = 1'b0;
    #1;
    check("t5_async_enable", {31'd0, enable6}, 32'd0);
    check("t5_async_counter", {26'd0, dut6.counter_q}, 32'd0);
    cycle();
    reset = 1'b1;
    tick_6();
    tick_6();
    check("t5_post_reset_enable", {31'd0, enable6}, 32'd0);
    start_6(6'd60, 1);
    check("t5_restart_enable", {31'd0, enable6}, 32'd1);
    for (int i = 1; i <= 4; i++) begin
      tick_6();
      check($sformatf("t5_tick%0d_enable", i), {31'd0, enable6}, (i < 4) ? 32'd1 : 32'd0);
    end

    // 6. Re-trigger after expiry, with a later length change ignored.
    start_6(6'd61, 1);
    length6 = 6'd0;
    check("t6_start_enable", {31'd0, enable6}, 32'd1);
    check("t6_start_counter", {26'd0, dut6.counter_q}, 32'd61);
    for (int i = 1; i <= 3; i++) begin
      tick_6();
      check($sformatf("t6_tick%0d_enable", i), {31'd0, enable6}, (i < 3) ? 32'd1 : 32'd0);
    end

    // 6b. 8-bit instance: 256-252 = 4 ticks.
    single8 = 1'b1; length8 = 8'd252; start8 = 1'b1;
    cycle();
    start8 = 1'b0;
    check("t6_w8_start_enable", {31'd0, enable8}, 32'd1);
    check("t6_w8_start_counter", {24'd0, dut8.counter_q}, 32'd252);
    for (int i = 1; i <= 5; i++) begin
      tick_8();
      check($sformatf("t6_w8_tick%0d_enable", i), {31'd0, enable8}, (i < 4) ? 32'd1 : 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
